stopwatch_countup: RTL and testbench

- Count-up stopwatch timer for the EGO1 stopwatch design. It is the up-counting counterpart of the countdown block.
- Runs from 00:00.00 in 0.01 s steps. Supports start/pause toggle, clear, and a lap capture register.
- Outputs minutes/seconds/centiseconds in the same binary field format the countdown block consumes, so its time can seed a countdown.
- Sits between the button debounce/pulse logic and the display mux.

---
 rtl/stopwatch_countup_if.sv | 26 ++
 rtl/stopwatch_countup.sv | 85 ++++++++
 tb/tb_stopwatch_countup.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stopwatch_countup_if.sv
// stopwatch_countup_if: button pulses in, live/lap time and status out
// master: the button/pulse side and the display side; slave: the stopwatch core
interface stopwatch_countup_if;
  logic start_stop;
  logic clear;
  logic lap;
  logic [6:0] centiseconds_out;
  logic [5:0] seconds_out;
  logic [5:0] minutes_out;
  logic [6:0] lap_centiseconds;
  logic [5:0] lap_seconds;
  logic [5:0] lap_minutes;
  logic lap_valid;
  logic running;
  logic overflow;
  modport master (
    output start_stop, clear, lap,
    input centiseconds_out, seconds_out, minutes_out,
    input lap_centiseconds, lap_seconds, lap_minutes, lap_valid, running, overflow
  );
  modport slave (
    input start_stop, clear, lap,
    output centiseconds_out, seconds_out, minutes_out,
    output lap_centiseconds, lap_seconds, lap_minutes, lap_valid, running, overflow
  );
endinterface

// File: rtl/stopwatch_countup.sv
// stopwatch_countup: count-up mm:ss.cc stopwatch with start/pause toggle, clear and lap capture
// Ports: clk; rst (asynchronous, active-high); bus (stopwatch_countup_if.slave) carrying the
//   start_stop/clear/lap pulses in and the registered live time, lap time, lap_valid,
//   running and overflow out.
// Optional: define STOPWATCH_SATURATE_EN to hold at MAX_MIN:59.99 (sticky overflow, forced
//   PAUSE) instead of wrapping to 00:00.00 with a one-cycle overflow pulse.
module stopwatch_countup #(
  parameter int TICK_DIV = 1_000_000,
  parameter int MAX_MIN = 59
) (
  input logic clk,
  input logic rst,
  stopwatch_countup_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
  logic [1:0] state, state_nxt;
  logic [PW-1:0] presc;
  logic tick, at_max, cs_wrap, sec_wrap, hold, ovf_nxt;
  logic [6:0] cs_nxt;
  logic [5:0] sec_nxt, min_nxt;
  always_comb begin
    tick = state == RUN && presc == LAST;
    cs_wrap = bus.centiseconds_out == 7'd99;
    sec_wrap = bus.seconds_out == 6'd59;
    at_max = cs_wrap && sec_wrap && bus.minutes_out == 6'(MAX_MIN);
    cs_nxt = cs_wrap ? 7'd0 : bus.centiseconds_out + 7'd1;
    sec_nxt = !cs_wrap ? bus.seconds_out : sec_wrap ? 6'd0 : bus.seconds_out + 6'd1;
    min_nxt = at_max ? 6'd0 : (cs_wrap && sec_wrap) ? bus.minutes_out + 6'd1 : bus.minutes_out;
`ifdef STOPWATCH_SATURATE_EN
    // once saturated the block is pinned in PAUSE and start_stop cannot resume it
    hold = bus.overflow || (tick && at_max);
    ovf_nxt = hold;
`else
    hold = 1'b0;
    ovf_nxt = tick && at_max;
`endif
    state_nxt = hold ? PAUSE : !bus.start_stop ? state : state == RUN ? PAUSE : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      bus.running <= 1'b0;
      bus.overflow <= 1'b0;
      bus.centiseconds_out <= '0;
      bus.seconds_out <= '0;
      bus.minutes_out <= '0;
      bus.lap_centiseconds <= '0;
      bus.lap_seconds <= '0;
      bus.lap_minutes <= '0;
      bus.lap_valid <= 1'b0;
    end else if (bus.clear) begin
      state <= IDLE;
      presc <= '0;
      bus.running <= 1'b0;
      bus.overflow <= 1'b0;
      bus.centiseconds_out <= '0;
      bus.seconds_out <= '0;
      bus.minutes_out <= '0;
      bus.lap_centiseconds <= '0;
      bus.lap_seconds <= '0;
      bus.lap_minutes <= '0;
      bus.lap_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      bus.running <= state_nxt == RUN;
      bus.overflow <= ovf_nxt;
      // outside RUN the fractional count is frozen so a resume finishes the partial tick
      presc <= state != RUN ? presc : tick ? '0 : presc + 1'b1;
      if (tick && !hold) begin
        bus.centiseconds_out <= cs_nxt;
        bus.seconds_out <= sec_nxt;
        bus.minutes_out <= min_nxt;
      end
      // captures the pre-increment time when a tick lands in the same cycle
      if (bus.lap && state != IDLE) begin
        bus.lap_centiseconds <= bus.centiseconds_out;
        bus.lap_seconds <= bus.seconds_out;
        bus.lap_minutes <= bus.minutes_out;
        bus.lap_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_stopwatch_countup.sv
// tb_stopwatch_countup: directed checks of the stopwatch with TICK_DIV=4, MAX_MIN=1
module tb_stopwatch_countup;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  stopwatch_countup_if bus();
  stopwatch_countup #(.TICK_DIV(4), .MAX_MIN(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int now_t();
    return int'(bus.minutes_out) * 10000 + int'(bus.seconds_out) * 100 + int'(bus.centiseconds_out);
  endfunction
  function automatic int lap_t();
    return int'(bus.lap_minutes) * 10000 + int'(bus.lap_seconds) * 100 + int'(bus.lap_centiseconds);
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic s, input logic c, input logic l);
    bus.start_stop = s;
    bus.clear = c;
    bus.lap = l;
    cyc(1);
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    bus.lap = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    bus.lap = 1'b0;
    cyc(2);
    chk("rst_time", now_t(), 0);
    chk("rst_lap", lap_t(), 0);
    chk("rst_flags", {bus.lap_valid, bus.running, bus.overflow}, 0);
    rst = 1'b0;
    cyc(1);
    pulse(1, 0, 0);
    chk("start_running", bus.running, 1);
    cyc(3);
    chk("pre_first_tick", now_t(), 0);
    cyc(1);
    chk("first_tick", now_t(), 1);
    cyc(396);
    chk("one_second", now_t(), 100);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    cyc(150);
    chk("run_to_37", now_t(), 37);
    pulse(1, 0, 0);
    chk("pause_running", bus.running, 0);
    cyc(50);
    chk("pause_hold", now_t(), 37);
    pulse(1, 0, 0);
    chk("resume_running", bus.running, 1);
    chk("resume_no_tick", now_t(), 37);
    cyc(1);
    chk("resume_partial", now_t(), 38);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    cyc(2051);
    chk("pre_lap", now_t(), 512);
    pulse(0, 0, 1);
    chk("lap_value", lap_t(), 512);
    chk("lap_valid", bus.lap_valid, 1);
    chk("lap_live", now_t(), 513);
    pulse(0, 1, 0);
    chk("clear_time", now_t(), 0);
    chk("clear_lap", lap_t(), 0);
    chk("clear_flags", {bus.lap_valid, bus.running, bus.overflow}, 0);
    pulse(1, 0, 0);
    cyc(23996);
    chk("to_59_99", now_t(), 5999);
    cyc(4);
    chk("min_carry", now_t(), 10000);
    cyc(23996);
    chk("to_max", now_t(), 15999);
    cyc(3);
    chk("pre_ovf", bus.overflow, 0);
    cyc(1);
`ifdef STOPWATCH_SATURATE_EN
    chk("sat_time", now_t(), 15999);
    chk("sat_ovf", bus.overflow, 1);
    chk("sat_running", bus.running, 0);
    pulse(1, 0, 0);
    cyc(8);
    chk("sat_ss_running", bus.running, 0);
    chk("sat_ss_time", now_t(), 15999);
    chk("sat_ss_ovf", bus.overflow, 1);
    pulse(0, 1, 0);
    chk("sat_clear_time", now_t(), 0);
    chk("sat_clear_ovf", bus.overflow, 0);
`else
    chk("wrap_time", now_t(), 0);
    chk("wrap_ovf", bus.overflow, 1);
    chk("wrap_running", bus.running, 1);
    cyc(1);
    chk("wrap_ovf_pulse", bus.overflow, 0);
    pulse(0, 1, 0);
`endif
    pulse(1, 1, 0);
    chk("clear_ss_idle", bus.running, 0);
    cyc(8);
    chk("idle_time", now_t(), 0);
    pulse(0, 0, 1);
    chk("idle_lap_ignored", bus.lap_valid, 0);
    pulse(1, 0, 0);
    cyc(9);
    pulse(1, 0, 1);
    chk("ss_lap_value", lap_t(), 2);
    chk("ss_lap_valid", bus.lap_valid, 1);
    chk("ss_lap_paused", bus.running, 0);
    pulse(1, 0, 0);
    cyc(5);
    chk("pre_rst_time", now_t(), 3);
    rst = 1'b1;
    #2;
    chk("async_rst_time", now_t(), 0);
    chk("async_rst_lap", lap_t(), 0);
    chk("async_rst_flags", {bus.lap_valid, bus.running, bus.overflow}, 0);
    cyc(1);
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
